// File: rtl/sim_serdes_pkg.sv
// Shared types and constants for the simulation SERDES models.
package sim_serdes_pkg;

  localparam int unsigned WORD_W         = 8;
  localparam int unsigned PAIRS_PER_WORD = 4;
  localparam int unsigned OFF_W          = 3;
  localparam int unsigned HIST_W         = 2 * WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HUNT   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } align_state_e;

  // Newest sample sits at hist[HIST_W-1]; offset o reaches o samples back.
  function automatic logic [WORD_W-1:0] word_at_offset(input logic [HIST_W-1:0] hist,
                                                       input logic [OFF_W-1:0]  off);
    return WORD_W'(hist >> (WORD_W - 32'(off)));
  endfunction

endpackage

// File: rtl/sim_iserdes_align_fsm.sv
// Training-word aligner: match counter, slip generator and lock/fail status.
module sim_iserdes_align_fsm
  import sim_serdes_pkg::*;
#(
  parameter logic [WORD_W-1:0] TRAIN_WORD = 8'hA5,
  parameter int unsigned       LOCK_COUNT = 4,
  parameter int unsigned       SLIP_WAIT  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              align_en_i,
  input  logic              word_valid_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              slip_o,
  output logic              locked_o,
  output logic              align_fail_o
);

  align_state_e state_q, state_d;
  logic [3:0]   match_q, match_d;
  logic [3:0]   tries_q, tries_d;
  logic [2:0]   wait_q,  wait_d;
  logic         en_q;

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    tries_d = tries_q;
    wait_d  = wait_q;
    slip_o  = 1'b0;
    if (!align_en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!en_q) begin
            state_d = ST_HUNT;
            match_d = '0;
            tries_d = '0;
          end
        end
        ST_HUNT: begin
          if (word_valid_i) begin
            if (word_i == TRAIN_WORD) begin
              match_d = match_q + 4'd1;
              if (match_d == 4'(LOCK_COUNT)) state_d = ST_LOCKED;
            end else begin
              match_d = '0;
              slip_o  = 1'b1;
              tries_d = tries_q + 4'd1;
              wait_d  = '0;
              // The slip that exhausts all offsets is still issued.
              state_d = (tries_d == 4'(WORD_W)) ? ST_FAIL : ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (word_valid_i) begin
            if (wait_q == 3'(SLIP_WAIT - 1)) state_d = ST_HUNT;
            else                              wait_d  = wait_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      match_q <= '0;
      tries_q <= '0;
      wait_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      tries_q <= tries_d;
      wait_q  <= wait_d;
      en_q    <= align_en_i;
    end
  end

  assign locked_o     = (state_q == ST_LOCKED);
  assign align_fail_o = (state_q == ST_FAIL);

endmodule

// File: rtl/sim_iserdes_align.sv
// Simulation 1:8 DDR deserializer with manual bitslip and training-word aligner.
module sim_iserdes_align
  import sim_serdes_pkg::*;
#(
  parameter logic [WORD_W-1:0] TRAIN_WORD = 8'hA5,
  parameter int unsigned       LOCK_COUNT = 4,
  parameter int unsigned       SLIP_WAIT  = 2
) (
  input  logic              clk_in,
  input  logic              io_reset,
  input  logic              data_in_from_pins_p,
  input  logic              data_in_from_pins_n,
  input  logic              bitslip,
  input  logic              align_en,
  output logic [WORD_W-1:0] data_in_to_device,
  output logic              data_valid,
  output logic [OFF_W-1:0]  slip_offset,
  output logic              locked,
  output logic              align_fail,
  output logic              diff_err
);

  localparam int unsigned PH_W = $clog2(PAIRS_PER_WORD);

  logic              held_q;
  logic              started_q;
  logic              diff_n_q;
  logic              diff_p_q;
  logic [HIST_W-1:0] hist_q;
  logic [PH_W-1:0]   phase_q;
  logic              grp_done_q;
  logic              valid_q;
  logic [WORD_W-1:0] data_q;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [1:0]        blk_q, blk_d;
  logic              fsm_slip;

  // Negedge sample is the earlier half of each pair; the first one starts numbering.
  always_ff @(negedge clk_in or posedge io_reset) begin
    if (io_reset) begin
      held_q    <= 1'b0;
      started_q <= 1'b0;
      diff_n_q  <= 1'b0;
    end else begin
      held_q    <= data_in_from_pins_p;
      started_q <= 1'b1;
      if (data_in_from_pins_p == data_in_from_pins_n) diff_n_q <= 1'b1;
    end
  end

  always_comb begin
    offset_d = offset_q;
    blk_d    = blk_q;
    if (!align_en && bitslip && (blk_q == '0)) begin
      offset_d = offset_q + 3'd1;
      blk_d    = 2'd2;
    end else if (grp_done_q && (blk_q != '0)) begin
      blk_d = blk_q - 2'd1;
    end
    if (align_en && fsm_slip) offset_d = offset_q + 3'd1;
  end

  always_ff @(posedge clk_in or posedge io_reset) begin
    if (io_reset) begin
      hist_q     <= '0;
      phase_q    <= '0;
      grp_done_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      offset_q   <= '0;
      blk_q      <= '0;
      diff_p_q   <= 1'b0;
    end else begin
      if (started_q) begin
        hist_q  <= {data_in_from_pins_p, held_q, hist_q[HIST_W-1:2]};
        phase_q <= phase_q + 1'b1;
      end
      grp_done_q <= started_q && (phase_q == PH_W'(PAIRS_PER_WORD - 1));
      valid_q    <= grp_done_q;
      if (grp_done_q) data_q <= word_at_offset(hist_q, offset_q);
      offset_q <= offset_d;
      blk_q    <= blk_d;
      if (data_in_from_pins_p == data_in_from_pins_n) diff_p_q <= 1'b1;
    end
  end

  sim_iserdes_align_fsm #(
    .TRAIN_WORD (TRAIN_WORD),
    .LOCK_COUNT (LOCK_COUNT),
    .SLIP_WAIT  (SLIP_WAIT)
  ) u_fsm (
    .clk_i        (clk_in),
    .rst_i        (io_reset),
    .align_en_i   (align_en),
    .word_valid_i (valid_q),
    .word_i       (data_q),
    .slip_o       (fsm_slip),
    .locked_o     (locked),
    .align_fail_o (align_fail)
  );

  assign data_in_to_device = data_q;
  assign data_valid        = valid_q;
  assign slip_offset       = offset_q;
  assign diff_err          = diff_p_q | diff_n_q;

endmodule
